// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares the single main-memory port between the loader (0),
//               D-cache (1) and I-cache (2). Each grant covers one full
//               cache-line burst of BEATS beats. The loader has absolute
//               priority and the two caches alternate round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
  parameter int XLEN  = 64,
  parameter int BEATS = 4
) (
  input  logic              i_riscv_arb_clk,
  input  logic              i_riscv_arb_rst_n,
  input  logic [2:0]        i_riscv_arb_req,
  input  logic [2:0]        i_riscv_arb_we,
  input  logic [3*XLEN-1:0] i_riscv_arb_addr,
  input  logic [3*XLEN-1:0] i_riscv_arb_wdata,
  output logic [2:0]        o_riscv_arb_gnt,
  output logic [2:0]        o_riscv_arb_beat_ack,
  output logic [XLEN-1:0]   o_riscv_arb_rdata,
  output logic [2:0]        o_riscv_arb_done,
  output logic              o_riscv_arb_mem_en,
  output logic              o_riscv_arb_mem_we,
  output logic [XLEN-1:0]   o_riscv_arb_mem_addr,
  output logic [XLEN-1:0]   o_riscv_arb_mem_wdata,
  input  logic [XLEN-1:0]   i_riscv_arb_mem_rdata,
  input  logic              i_riscv_arb_mem_valid
);

  localparam int            LB          = $clog2(BEATS * 8);
  localparam int            BW          = LB - 3;
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state,      w_state_nxt;
  logic [1:0]      r_owner,      w_owner_nxt;
  logic [2:0]      r_gnt,        w_gnt_nxt;
  logic            r_we,         w_we_nxt;
  logic [XLEN-1:0] r_base,       w_base_nxt;
  logic [BW-1:0]   r_beat,       w_beat_nxt;
  // 1 means the I-cache wins a tie against the D-cache.
  logic            r_rr_icache,  w_rr_icache_nxt;
  // Command fields captured in ISSUE so they hold steady while waiting.
  logic            r_cmd_we,     w_cmd_we_nxt;
  logic [XLEN-1:0] r_cmd_addr,   w_cmd_addr_nxt;
  logic [XLEN-1:0] r_cmd_wdata,  w_cmd_wdata_nxt;

  logic [1:0]      w_win;
  logic            w_win_we;
  logic [XLEN-1:0] w_win_addr;
  logic [XLEN-1:0] w_own_wdata;
  logic [BW-1:0]   w_line_idx;
  logic [XLEN-1:0] w_beat_addr;
  logic            w_ack;
  logic            w_last;

  // Beat index wraps inside the line, giving critical-word-first order.
  assign w_line_idx  = r_base[LB-1:3] + r_beat;
  assign w_beat_addr = {r_base[XLEN-1:LB], w_line_idx, 3'b000};
  assign w_ack       = (r_state == S_WAIT) && i_riscv_arb_mem_valid;
  assign w_last      = (r_beat == C_LAST_BEAT);

  // Pick the arbitration winner and select per-requester slices.
  always_comb begin
    w_win       = 2'd2;
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_own_wdata = '0;
    if (i_riscv_arb_req[0]) begin
      w_win = 2'd0;
    end else if (i_riscv_arb_req[1] && i_riscv_arb_req[2]) begin
      w_win = r_rr_icache ? 2'd2 : 2'd1;
    end else if (i_riscv_arb_req[1]) begin
      w_win = 2'd1;
    end
    case (w_win)
      2'd0:    begin w_win_we = i_riscv_arb_we[0]; w_win_addr = i_riscv_arb_addr[0 +: XLEN]; end
      2'd1:    begin w_win_we = i_riscv_arb_we[1]; w_win_addr = i_riscv_arb_addr[XLEN +: XLEN]; end
      default: begin w_win_we = i_riscv_arb_we[2]; w_win_addr = i_riscv_arb_addr[2*XLEN +: XLEN]; end
    endcase
    case (r_owner)
      2'd0:    w_own_wdata = i_riscv_arb_wdata[0 +: XLEN];
      2'd1:    w_own_wdata = i_riscv_arb_wdata[XLEN +: XLEN];
      default: w_own_wdata = i_riscv_arb_wdata[2*XLEN +: XLEN];
    endcase
  end

  // Next-state logic for the burst FSM and its bookkeeping registers.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_gnt_nxt       = r_gnt;
    w_we_nxt        = r_we;
    w_base_nxt      = r_base;
    w_beat_nxt      = r_beat;
    w_rr_icache_nxt = r_rr_icache;
    w_cmd_we_nxt    = r_cmd_we;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_wdata_nxt = r_cmd_wdata;
    case (r_state)
      S_IDLE: begin
        if (|i_riscv_arb_req) begin
          w_owner_nxt = w_win;
          w_gnt_nxt   = 3'b001 << w_win;
          w_we_nxt    = w_win_we;
          w_base_nxt  = w_win_addr;
          w_beat_nxt  = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cmd_we_nxt    = r_we;
        w_cmd_addr_nxt  = w_beat_addr;
        w_cmd_wdata_nxt = w_own_wdata;
        w_state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (i_riscv_arb_mem_valid) begin
          if (w_last) begin
            w_beat_nxt  = '0;
            w_gnt_nxt   = 3'b000;
            w_state_nxt = S_IDLE;
            if (r_owner == 2'd1) w_rr_icache_nxt = 1'b1;
            if (r_owner == 2'd2) w_rr_icache_nxt = 1'b0;
          end else begin
            w_beat_nxt  = r_beat + BW'(1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
    if (!i_riscv_arb_rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= 2'd0;
      r_gnt       <= 3'b000;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_beat      <= '0;
      r_rr_icache <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_gnt       <= w_gnt_nxt;
      r_we        <= w_we_nxt;
      r_base      <= w_base_nxt;
      r_beat      <= w_beat_nxt;
      r_rr_icache <= w_rr_icache_nxt;
      r_cmd_we    <= w_cmd_we_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
    end
  end

  assign o_riscv_arb_gnt       = r_gnt;
  assign o_riscv_arb_beat_ack  = w_ack ? r_gnt : 3'b000;
  assign o_riscv_arb_done      = (w_ack && w_last) ? r_gnt : 3'b000;
  assign o_riscv_arb_rdata     = (w_ack && !r_we) ? i_riscv_arb_mem_rdata : '0;
  assign o_riscv_arb_mem_en    = (r_state == S_ISSUE);
  assign o_riscv_arb_mem_we    = (r_state == S_ISSUE) ? r_we        : r_cmd_we;
  assign o_riscv_arb_mem_addr  = (r_state == S_ISSUE) ? w_beat_addr : r_cmd_addr;
  assign o_riscv_arb_mem_wdata = (r_state == S_ISSUE) ? w_own_wdata : r_cmd_wdata;

endmodule
`default_nettype wire
